// File: rtl/subtractor_4bit_pkg.sv
// Purpose : shared width constant, nibble type and bit-level helpers for the 4-bit subtractor.
// Latency : n/a (declarations only).
// Backpressure: n/a (no handshake; package has no ports).
package subtractor_4bit_pkg;

    localparam int SUB_W = 4;

    typedef logic [SUB_W-1:0] nibble_t;

    // Subtraction is A + ~B + 1, so the ripple chain always starts with a set carry.
    localparam logic SUB_CIN = 1'b1;

    // Registered-build reset values of the outputs.
    localparam nibble_t DIFF_RST  = '0;
    localparam logic    CARRY_RST = 1'b0;

    // Carry of a full adder: set when at least two of the three inputs are set.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage : subtractor_4bit_pkg

// File: rtl/full_adder_1bit.sv
// Purpose : single-bit full adder, one ripple stage of the subtractor chain.
// Latency : combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   a, b  - addend bits
//   cin   - carry in from the previous stage
//   sum   - a ^ b ^ cin
//   cout  - majority(a, b, cin)
module full_adder_1bit
    import subtractor_4bit_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule : full_adder_1bit

// File: rtl/subtractor_4bit.sv
// Purpose : unsigned 4-bit subtract, difference = (minuend - subtrahend) mod 16, carry = no-borrow.
// Latency : 0 cycles by default; exactly 1 cycle when SUB4_OUTPUT_REG_EN is defined.
// Backpressure: none; a new operand pair may be presented every cycle.
//
// Ports:
//   clk        - system clock (only used when SUB4_OUTPUT_REG_EN is defined)
//   reset      - synchronous active-high reset (only used when SUB4_OUTPUT_REG_EN is defined)
//   minuend    - operand A
//   subtrahend - operand B
//   difference - (A - B) mod 16
//   carry      - carry-out of A + ~B + 1; 1 means A >= B, 0 means a borrow occurred
//
// Build option: define SUB4_OUTPUT_REG_EN to register difference/carry on rising clk.
module subtractor_4bit
    import subtractor_4bit_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  nibble_t minuend,
    input  nibble_t subtrahend,
    output nibble_t difference,
    output logic    carry
);

    nibble_t          sub_inv;
    logic [SUB_W:0]   c;
    nibble_t          diff_d;
    logic             carry_d;

    // Two's-complement negate of B without a separate incrementer: the +1 rides
    // in as the chain's carry-in.
    assign sub_inv = ~subtrahend;
    assign c[0]    = SUB_CIN;

    for (genvar i = 0; i < SUB_W; i++) begin : g_fa
        full_adder_1bit u_fa (
            .a    (minuend[i]),
            .b    (sub_inv[i]),
            .cin  (c[i]),
            .sum  (diff_d[i]),
            .cout (c[i+1])
        );
    end

    assign carry_d = c[SUB_W];

`ifdef SUB4_OUTPUT_REG_EN
    nibble_t diff_q;
    logic    carry_q;

    // Reset wins over the incoming operands, so a result in flight when reset
    // is asserted never reaches the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            diff_q  <= DIFF_RST;
            carry_q <= CARRY_RST;
        end else begin
            diff_q  <= diff_d;
            carry_q <= carry_d;
        end
    end

    assign difference = diff_q;
    assign carry      = carry_q;
`else
    // Purely combinational build: clk and reset are kept on the port list so the
    // instance footprint is identical in both builds, but nothing reads them.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    assign difference = diff_d;
    assign carry      = carry_d;
`endif

endmodule : subtractor_4bit

// File: tb/tb_subtractor_4bit.sv
module tb_subtractor_4bit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] minuend;
    logic [3:0] subtrahend;
    logic [3:0] difference;
    logic       carry;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    subtractor_4bit dut (
        .clk        (clk),
        .reset      (reset),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .difference (difference),
        .carry      (carry)
    );

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [3:0] ref_diff(input int a, input int b);
        int d;
        d = a - b;
        if (d < 0) d = d + 16;
        return d[3:0];
    endfunction

    function automatic logic ref_carry(input int a, input int b);
        return (a >= b);
    endfunction

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s a=%0d b=%0d rst=%b got=%0d expected=%0d",
                     tag, minuend, subtrahend, reset, got, exp);
        end
    endtask

`ifndef SUB4_OUTPUT_REG_EN
    // Combinational build: drive, settle 10 ns, compare.
    task automatic apply_comb(input int a, input int b, input string tag);
        minuend    = 4'(a);
        subtrahend = 4'(b);
        #10;
        check_val({tag, "_diff"}, {4'h0, difference}, {4'h0, ref_diff(a, b)});
        check_val({tag, "_carry"}, {7'h0, carry}, {7'h0, ref_carry(a, b)});
    endtask

    initial begin
        reset      = 1'b1;
        minuend    = '0;
        subtrahend = '0;
        // Reset has no effect on a combinational result.
        apply_comb(9, 4, "in_reset");
        @(negedge clk);
        apply_comb(0, 1, "in_reset_wrap");
        reset = 1'b0;

        apply_comb(9, 4, "dir_9_4");
        apply_comb(0, 1, "wrap_0_1");
        apply_comb(3, 15, "wrap_3_15");
        apply_comb(7, 7, "equal_7_7");
        apply_comb(12, 0, "zero_12_0");
        apply_comb(15, 15, "equal_15_15");
        apply_comb(0, 15, "wrap_0_15");
        apply_comb(15, 0, "max_15_0");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                apply_comb(a, b, "exh");
            end
        end

        for (int n = 0; n < 200; n++) begin
            reset = 1'($urandom_range(0, 1));
            apply_comb(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`else
    // Registered build: drive on the falling edge, check just before and just
    // after the rising edge against the value the model says is held.
    logic [3:0] exp_d;
    logic       exp_c;

    task automatic reg_cycle(input int a, input int b, input logic rst, input string tag);
        @(negedge clk);
        minuend    = 4'(a);
        subtrahend = 4'(b);
        reset      = rst;
        #1;
        check_val({tag, "_hold_diff"}, {4'h0, difference}, {4'h0, exp_d});
        check_val({tag, "_hold_carry"}, {7'h0, carry}, {7'h0, exp_c});
        @(posedge clk);
        if (rst) begin
            exp_d = 4'h0;
            exp_c = 1'b0;
        end else begin
            exp_d = ref_diff(a, b);
            exp_c = ref_carry(a, b);
        end
        #1;
        check_val({tag, "_diff"}, {4'h0, difference}, {4'h0, exp_d});
        check_val({tag, "_carry"}, {7'h0, carry}, {7'h0, exp_c});
    endtask

    initial begin
        reset      = 1'b1;
        minuend    = 4'd5;
        subtrahend = 4'd2;
        @(posedge clk);
        exp_d = 4'h0;
        exp_c = 1'b0;
        #1;
        check_val("rst_diff", {4'h0, difference}, 8'h0);
        check_val("rst_carry", {7'h0, carry}, 8'h0);

        reg_cycle(9, 4, 1'b0, "dir_9_4");
        reg_cycle(0, 1, 1'b1, "rst_hold");
        reg_cycle(0, 1, 1'b0, "rst_release");
        reg_cycle(3, 15, 1'b0, "wrap_3_15");
        reg_cycle(7, 7, 1'b0, "equal_7_7");
        reg_cycle(12, 0, 1'b0, "zero_12_0");

        for (int n = 0; n < 300; n++) begin
            reg_cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      ($urandom_range(0, 9) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`endif

endmodule : tb_subtractor_4bit
